voice_alloc: RTL and testbench
==============================

VOICE_ALLOC -- requirements
Module: voice_alloc

Interface
REQ-001 SHALL have parameter VOICES, default `OSC_VOICES (8), number of oscillator voices managed, range 2..16.
REQ-002 SHALL have parameter NOTE_BITS, default `MIDI_PAYLOAD_BITS (7), MIDI note number width.
REQ-003 SHALL have clk_i input 1, system clock; all state changes on its rising edge.
REQ-004 SHALL have nrst_i input 1, reset; asynchronous, active-low.
REQ-005 SHALL have noteOnStrb_i input 1, one-cycle note-on event from the MIDI decoder.
REQ-006 SHALL have noteOffStrb_i input 1, one-cycle note-off event from the MIDI decoder.
REQ-007 SHALL have note_i input NOTE_BITS, note number, valid in the strobe cycle.
REQ-008 SHALL have voiceNote_o output VOICES*NOTE_BITS, per-voice note; voice v occupies bits [v*NOTE_BITS +: NOTE_BITS].
REQ-009 SHALL have voiceEn_o output VOICES, per-voice enable.
REQ-010 SHALL have busy_o output 1, high while the FSM is not IDLE or the event FIFO is not empty.
REQ-011 SHALL have dropStrb_o output 1, one-cycle pulse when an event is discarded.
REQ-012 SHALL have stealStrb_o output 1, one-cycle pulse when an active voice is reassigned.

Function
REQ-013 SHALL capture each strobe with its note and type into a 2-entry event FIFO; a push is accepted when the FIFO is not full or when a pop occurs in the same cycle.
REQ-014 SHALL discard a strobe arriving while the FIFO is full with no pop that cycle, and pulse dropStrb_o in the following cycle.
REQ-015 SHALL give noteOnStrb_i priority when both strobes are high in one cycle; the note-off is discarded and dropStrb_o pulses.
REQ-016 SHALL use FSM states IDLE->SCAN->COMMIT->IDLE; IDLE pops the FIFO when non-empty; SCAN registers the match index, first free index and victim index; COMMIT writes the voice registers.
REQ-017 SHALL update voiceNote_o and voiceEn_o on the third rising edge after the sampling edge when the block is idle: sample at edge 0, pop at edge 1, scan at edge 2, commit at edge 3.
REQ-018 SHALL, on note-on matching an enabled voice's note, retrigger that voice only: age cleared, no second voice allocated.
REQ-019 SHALL, on note-on with no match, assign the lowest-index disabled voice: note written, enable set, age cleared.
REQ-020 SHALL, on note-off, clear the enable of the matching enabled voice; with no match, no state change and no drop pulse.
REQ-021 SHALL keep an 8-bit per-voice age, saturating at 255; on each commit of a note-on, all other enabled voices increment.
REQ-022 SHALL leave voiceNote_o unchanged when a voice is disabled.

Reset
REQ-023 SHALL asynchronously clear all voice notes, enables and ages, empty the FIFO, enter IDLE, and drive busy_o, dropStrb_o and stealStrb_o to 0.
REQ-024 SHALL discard any in-flight event on reset mid-operation, with no partial voice update.

Configuration
REQ-025 SHALL, with VOICE_STEAL_EN defined, assign a note-on with no match and no free voice to the voice with the highest age (ties: lowest index), and pulse stealStrb_o in the COMMIT-following cycle.
REQ-026 SHALL, without VOICE_STEAL_EN, discard such a note-on, pulse dropStrb_o, and tie stealStrb_o to 0.

Structure
REQ-027 SHALL take OSC_VOICES and MIDI_PAYLOAD_BITS from the shared global.v include; FIFO depth and age width SHALL be defined there as VALLOC_FIFO_DEPTH (2) and VALLOC_AGE_BITS (8).
REQ-028 SHALL implement the event FIFO as a sub-module named voice_evt_fifo; the scan/allocation logic stays in voice_alloc.

Verification
REQ-029 SHALL verify: note-on 60 after reset -> voice 0 enabled, note 60, at edge 3; voiceEn_o=8'h01.
REQ-030 SHALL verify: note-ons 60, 64, 67, then note-off 64 -> voiceEn_o goes 8'h07 then 8'h05; note-off 70 -> no change, no drop.
REQ-031 SHALL verify: note-on 60 twice -> voiceEn_o stays 8'h01, voice 0 age 0.
REQ-032 SHALL verify: 9 distinct note-ons with VOICES=8 -> with VOICE_STEAL_EN, voice 0 (oldest) takes the 9th note and stealStrb_o pulses once; without it, dropStrb_o pulses and voice notes are unchanged.
REQ-033 SHALL verify: three strobes on consecutive cycles while busy -> third accepted only if a pop coincides, otherwise dropStrb_o pulses; plus simultaneous on/off -> note-on processed, one drop pulse.
REQ-034 SHALL verify: nrst_i asserted during SCAN -> all outputs 0 immediately; no update after release.

Source files
------------

// File: rtl/voice_alloc_pkg.sv
// Types, sizing constants and the saturating age helper shared by the voice allocator.
`include "global.v"

package voice_alloc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } valloc_state_t;

  localparam int AGE_BITS   = `VALLOC_AGE_BITS;
  localparam int FIFO_DEPTH = `VALLOC_FIFO_DEPTH;
  localparam logic [AGE_BITS-1:0] AGE_MAX = '1;

  function automatic logic [AGE_BITS-1:0] age_inc(input logic [AGE_BITS-1:0] a);
    return (a == AGE_MAX) ? a : a + 1'b1;
  endfunction

endpackage

// File: rtl/global.v
// Shared synth-wide defines: voice count, MIDI payload width and voice allocator sizing.
`ifndef GLOBAL_V
`define GLOBAL_V
`define OSC_VOICES 8
`define MIDI_PAYLOAD_BITS 7
`define VALLOC_FIFO_DEPTH 2
`define VALLOC_AGE_BITS 8
`endif

// File: rtl/voice_evt_fifo.sv
// Small event FIFO between the MIDI decoder strobes and the allocator FSM.
// A push into a full FIFO is still accepted when a pop happens in the same cycle.
module voice_evt_fifo
  import voice_alloc_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic          clk_i,
  input  logic          nrst_i,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic          accept,
  output logic          empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][DW-1:0] mem_q;
  logic [PW-1:0]            wr_q, rd_q;
  logic [CW-1:0]            cnt_q;
  logic                     full, do_pop;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CW'(DEPTH));
  assign do_pop   = pop && !empty;
  assign accept   = push && (!full || do_pop);
  assign pop_data = mem_q[rd_q];

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (accept) begin
        mem_q[wr_q] <= push_data;
        wr_q        <= nxt(wr_q);
      end
      if (do_pop) rd_q <= nxt(rd_q);
      case ({accept, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: queues note-on/off strobes and assigns them to oscillator voices.
// Define VOICE_STEAL_EN to let a note-on with no free voice take over the oldest voice.
`include "global.v"

module voice_alloc
  import voice_alloc_pkg::*;
#(
  parameter int VOICES    = `OSC_VOICES,
  parameter int NOTE_BITS = `MIDI_PAYLOAD_BITS
) (
  input  logic                        clk_i,
  input  logic                        nrst_i,
  input  logic                        noteOnStrb_i,
  input  logic                        noteOffStrb_i,
  input  logic [NOTE_BITS-1:0]        note_i,
  output logic [VOICES*NOTE_BITS-1:0] voiceNote_o,
  output logic [VOICES-1:0]           voiceEn_o,
  output logic                        busy_o,
  output logic                        dropStrb_o,
  output logic                        stealStrb_o
);

  localparam int IW = $clog2(VOICES);
  localparam int EW = NOTE_BITS + 1;

  valloc_state_t                     state_q;
  logic [VOICES-1:0][NOTE_BITS-1:0]  note_q;
  logic [VOICES-1:0]                 en_q;
  logic [VOICES-1:0][AGE_BITS-1:0]   age_q;
  logic                              evt_on_q;
  logic [NOTE_BITS-1:0]              evt_note_q;
  logic                              match_vld_q, free_vld_q;
  logic [IW-1:0]                     match_idx_q, free_idx_q;
  logic                              drop_q;

  logic          push, pop, accept, empty, fifo_drop;
  logic [EW-1:0] pop_data;

  // Event type bit is the note-on strobe, so a simultaneous on/off queues the note-on.
  assign push      = noteOnStrb_i | noteOffStrb_i;
  assign pop       = (state_q == IDLE) && !empty;
  assign fifo_drop = (noteOnStrb_i && noteOffStrb_i) || (push && !accept);

  voice_evt_fifo #(.DW(EW)) u_fifo (
    .clk_i    (clk_i),
    .nrst_i   (nrst_i),
    .push     (push),
    .push_data({noteOnStrb_i, note_i}),
    .pop      (pop),
    .pop_data (pop_data),
    .accept   (accept),
    .empty    (empty)
  );

  logic          hit_any, free_any;
  logic [IW-1:0] hit_idx, free_idx;

  always_comb begin
    hit_any  = 1'b0;
    free_any = 1'b0;
    hit_idx  = '0;
    free_idx = '0;
    for (int v = VOICES - 1; v >= 0; v--) begin
      if (en_q[v] && note_q[v] == evt_note_q) begin
        hit_any = 1'b1;
        hit_idx = IW'(v);
      end
      if (!en_q[v]) begin
        free_any = 1'b1;
        free_idx = IW'(v);
      end
    end
  end

`ifdef VOICE_STEAL_EN
  logic [IW-1:0]       vic_idx, vic_idx_q;
  logic [AGE_BITS-1:0] vic_age;
  logic                steal_q;

  // Strict compare keeps the lowest index on equal ages.
  always_comb begin
    vic_idx = '0;
    vic_age = age_q[0];
    for (int v = 1; v < VOICES; v++) begin
      if (age_q[v] > vic_age) begin
        vic_age = age_q[v];
        vic_idx = IW'(v);
      end
    end
  end
  assign stealStrb_o = steal_q;
`else
  assign stealStrb_o = 1'b0;
`endif

  logic          wr_vld, off_clr, commit_drop, commit_steal;
  logic [IW-1:0] wr_idx;

  always_comb begin
    wr_vld       = 1'b0;
    wr_idx       = match_idx_q;
    commit_drop  = 1'b0;
    commit_steal = 1'b0;
    off_clr      = (state_q == COMMIT) && !evt_on_q && match_vld_q;
    if (state_q == COMMIT && evt_on_q) begin
      if (match_vld_q) begin
        wr_vld = 1'b1;
      end else if (free_vld_q) begin
        wr_vld = 1'b1;
        wr_idx = free_idx_q;
      end else begin
`ifdef VOICE_STEAL_EN
        wr_vld       = 1'b1;
        wr_idx       = vic_idx_q;
        commit_steal = 1'b1;
`else
        commit_drop  = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q     <= IDLE;
      note_q      <= '0;
      en_q        <= '0;
      age_q       <= '0;
      evt_on_q    <= 1'b0;
      evt_note_q  <= '0;
      match_vld_q <= 1'b0;
      free_vld_q  <= 1'b0;
      match_idx_q <= '0;
      free_idx_q  <= '0;
      drop_q      <= 1'b0;
`ifdef VOICE_STEAL_EN
      vic_idx_q   <= '0;
      steal_q     <= 1'b0;
`endif
    end else begin
      drop_q <= fifo_drop | commit_drop;
`ifdef VOICE_STEAL_EN
      steal_q <= commit_steal;
`endif
      case (state_q)
        IDLE: begin
          if (!empty) begin
            evt_on_q   <= pop_data[NOTE_BITS];
            evt_note_q <= pop_data[NOTE_BITS-1:0];
            state_q    <= SCAN;
          end
        end
        SCAN: begin
          match_vld_q <= hit_any;
          match_idx_q <= hit_idx;
          free_vld_q  <= free_any;
          free_idx_q  <= free_idx;
`ifdef VOICE_STEAL_EN
          vic_idx_q   <= vic_idx;
`endif
          state_q     <= COMMIT;
        end
        COMMIT: begin
          for (int v = 0; v < VOICES; v++) begin
            if (wr_vld && wr_idx == IW'(v)) begin
              note_q[v] <= evt_note_q;
              en_q[v]   <= 1'b1;
              age_q[v]  <= '0;
            end else if (wr_vld && en_q[v]) begin
              age_q[v] <= age_inc(age_q[v]);
            end
            if (off_clr && match_idx_q == IW'(v)) en_q[v] <= 1'b0;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign voiceNote_o = note_q;
  assign voiceEn_o   = en_q;
  assign busy_o      = (state_q != IDLE) || !empty;
  assign dropStrb_o  = drop_q;

endmodule

// File: tb/tb_voice_alloc.sv
// Directed bench for voice_alloc: vector table for allocation behaviour plus hand sequences
// for latency, FIFO overflow, voice exhaustion and mid-operation reset.
module tb_voice_alloc;

  localparam int V  = 8;
  localparam int NB = 7;

  logic          clk_i = 1'b0;
  logic          nrst_i;
  logic          noteOnStrb_i, noteOffStrb_i;
  logic [NB-1:0] note_i;
  logic [V*NB-1:0] voiceNote_o;
  logic [V-1:0]  voiceEn_o;
  logic          busy_o, dropStrb_o, stealStrb_o;

  voice_alloc #(.VOICES(V), .NOTE_BITS(NB)) dut (
    .clk_i        (clk_i),
    .nrst_i       (nrst_i),
    .noteOnStrb_i (noteOnStrb_i),
    .noteOffStrb_i(noteOffStrb_i),
    .note_i       (note_i),
    .voiceNote_o  (voiceNote_o),
    .voiceEn_o    (voiceEn_o),
    .busy_o       (busy_o),
    .dropStrb_o   (dropStrb_o),
    .stealStrb_o  (stealStrb_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;
  int drop_cnt = 0;
  int steal_cnt = 0;

  typedef struct {
    logic          on;
    logic          off;
    logic [NB-1:0] note;
    logic [V-1:0]  exp_en;
    logic [V*NB-1:0] exp_notes;
    int            exp_drop;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [V*NB-1:0] nv(input int n0, input int n1, input int n2, input int n3);
    logic [V*NB-1:0] r;
    r = '0;
    r[0*NB +: NB] = NB'(n0);
    r[1*NB +: NB] = NB'(n1);
    r[2*NB +: NB] = NB'(n2);
    r[3*NB +: NB] = NB'(n3);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
    drop_cnt  += int'(dropStrb_o);
    steal_cnt += int'(stealStrb_o);
  endtask

  task automatic send(input logic on, input logic off, input int note);
    noteOnStrb_i  = on;
    noteOffStrb_i = off;
    note_i        = NB'(note);
    step();
    noteOnStrb_i  = 1'b0;
    noteOffStrb_i = 1'b0;
  endtask

  task automatic do_reset();
    noteOnStrb_i  = 1'b0;
    noteOffStrb_i = 1'b0;
    note_i        = '0;
    nrst_i        = 1'b0;
    @(posedge clk_i);
    @(posedge clk_i);
    #3 nrst_i = 1'b1;
    @(posedge clk_i);
    #1;
    drop_cnt  = 0;
    steal_cnt = 0;
  endtask

  logic [V*NB-1:0] exp_n;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 7'd60, 8'h01, nv(60, 0, 0, 0), 0};
    vecs[1] = '{1'b1, 1'b0, 7'd64, 8'h03, nv(60, 64, 0, 0), 0};
    vecs[2] = '{1'b1, 1'b0, 7'd67, 8'h07, nv(60, 64, 67, 0), 0};
    vecs[3] = '{1'b0, 1'b1, 7'd64, 8'h05, nv(60, 64, 67, 0), 0};
    vecs[4] = '{1'b0, 1'b1, 7'd70, 8'h05, nv(60, 64, 67, 0), 0};
    vecs[5] = '{1'b1, 1'b0, 7'd60, 8'h05, nv(60, 64, 67, 0), 0};
    vecs[6] = '{1'b1, 1'b0, 7'd72, 8'h07, nv(60, 72, 67, 0), 0};
    vecs[7] = '{1'b1, 1'b1, 7'd64, 8'h0F, nv(60, 72, 67, 64), 1};
    vecs[8] = '{1'b0, 1'b1, 7'd60, 8'h0E, nv(60, 72, 67, 64), 0};
    vecs[9] = '{1'b1, 1'b0, 7'd55, 8'h0F, nv(55, 72, 67, 64), 0};

    // reset state
    do_reset();
    chk("rst_en", voiceEn_o, 0);
    chk("rst_notes", voiceNote_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_drop", dropStrb_o, 0);
    chk("rst_steal", stealStrb_o, 0);

    // first note-on latency: commit lands on the third edge after sampling
    send(1'b1, 1'b0, 60);
    chk("lat_busy_e0", busy_o, 1);
    step();
    step();
    chk("lat_en_e2", voiceEn_o, 8'h00);
    step();
    chk("lat_en_e3", voiceEn_o, 8'h01);
    chk("lat_note_e3", voiceNote_o, nv(60, 0, 0, 0));
    chk("lat_busy_e3", busy_o, 0);

    // allocation table
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drop_cnt = 0;
      send(vecs[i].on, vecs[i].off, int'(vecs[i].note));
      repeat (4) step();
      chk($sformatf("vec%0d_en", i), voiceEn_o, vecs[i].exp_en);
      chk($sformatf("vec%0d_notes", i), voiceNote_o, vecs[i].exp_notes);
      chk($sformatf("vec%0d_drop", i), drop_cnt, vecs[i].exp_drop);
    end

    // retrigger and ageing
    do_reset();
    send(1'b1, 1'b0, 60); repeat (4) step();
    send(1'b1, 1'b0, 64); repeat (4) step();
    chk("age0_after_2", dut.age_q[0], 1);
    send(1'b1, 1'b0, 60); repeat (4) step();
    chk("retrig_en", voiceEn_o, 8'h03);
    chk("retrig_age0", dut.age_q[0], 0);
    chk("retrig_age1", dut.age_q[1], 1);
    do_reset();
    send(1'b1, 1'b0, 60); repeat (4) step();
    send(1'b1, 1'b0, 60); repeat (4) step();
    chk("dup_en", voiceEn_o, 8'h01);
    chk("dup_age0", dut.age_q[0], 0);

    // voice exhaustion: 9 distinct note-ons
    do_reset();
    exp_n = '0;
    for (int i = 0; i < 9; i++) begin
      send(1'b1, 1'b0, 40 + i);
      repeat (4) step();
      if (i < 8) exp_n[i*NB +: NB] = NB'(40 + i);
    end
`ifdef VOICE_STEAL_EN
    exp_n[0 +: NB] = NB'(48);
    chk("steal_cnt", steal_cnt, 1);
    chk("steal_drop", drop_cnt, 0);
`else
    chk("nosteal_cnt", steal_cnt, 0);
    chk("nosteal_drop", drop_cnt, 1);
`endif
    chk("full_en", voiceEn_o, 8'hFF);
    chk("full_notes", voiceNote_o, exp_n);

    // three back-to-back strobes from idle: a pop coincides, all accepted
    do_reset();
    for (int i = 0; i < 3; i++) send(1'b1, 1'b0, 10 + i);
    repeat (12) step();
    chk("b2b3_drop", drop_cnt, 0);
    chk("b2b3_en", voiceEn_o, 8'h07);
    chk("b2b3_busy", busy_o, 0);

    // three strobes while busy, the third lands on the IDLE pop edge
    do_reset();
    send(1'b1, 1'b0, 10);
    step();
    for (int i = 1; i < 4; i++) send(1'b1, 1'b0, 10 + i);
    repeat (14) step();
    chk("popcoin_drop", drop_cnt, 0);
    chk("popcoin_en", voiceEn_o, 8'h0F);

    // four back-to-back strobes: the fourth hits a full FIFO during COMMIT
    do_reset();
    for (int i = 0; i < 4; i++) send(1'b1, 1'b0, 20 + i);
    chk("ovf_drop_pulse", dropStrb_o, 1);
    repeat (12) step();
    chk("ovf_drop_cnt", drop_cnt, 1);
    chk("ovf_en", voiceEn_o, 8'h07);
    chk("ovf_notes", voiceNote_o, nv(20, 21, 22, 0));

    // reset asserted while the FSM is in SCAN
    do_reset();
    send(1'b1, 1'b0, 60); repeat (4) step();
    send(1'b1, 1'b0, 64);
    step();
    #2 nrst_i = 1'b0;
    #1;
    chk("midrst_en", voiceEn_o, 0);
    chk("midrst_notes", voiceNote_o, 0);
    chk("midrst_busy", busy_o, 0);
    @(posedge clk_i);
    #3 nrst_i = 1'b1;
    drop_cnt = 0;
    steal_cnt = 0;
    repeat (6) step();
    chk("postrst_en", voiceEn_o, 0);
    chk("postrst_notes", voiceNote_o, 0);
    chk("postrst_busy", busy_o, 0);
    chk("postrst_drop", drop_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
